// File: rtl/run_len_detect_pkg.sv
// Shared definitions for the run-length detector.
//   state_t : run-tracking FSM states
//     ST_IDLE - no run in progress (count is zero)
//     ST_RUN  - run in progress, count below full scale
//     ST_SAT  - run saturated at full scale
package run_len_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SAT  = 2'd2
  } state_t;

endpackage

// File: rtl/run_len_detect_flopr_en.sv
// Generic register with synchronous clear and load enable.
//   clk  : rising-edge clock
//   clr  : synchronous clear, dominates en
//   en   : load enable
//   d    : data in
//   q    : registered data out
module flopr_en #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/run_len_detect.sv
// Run-length detector for a 1-bit serial stream.
// Counts the current run of bits equal to i_pol (saturating at 2**WIDTH-1),
// flags when the run reaches i_thresh and captures each completed run length.
//   clk         : rising-edge clock
//   i_sclr      : synchronous clear, highest priority
//   i_en        : sample qualifier
//   i_dat       : serial data bit
//   i_pol       : polarity counted (1 = ones, 0 = zeros)
//   i_thresh    : hit threshold, 0 disables hit logic
//   o_cnt       : current run length
//   o_sat       : current run saturated
//   o_hit       : level, run length at or above a nonzero threshold
//   o_hit_pulse : one-cycle pulse when the run first reaches i_thresh
//   o_run_len   : length of the last completed run
//   o_run_vld   : one-cycle pulse, o_run_len updated
module run_len_detect
  import run_len_detect_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             i_sclr,
  input  logic             i_en,
  input  logic             i_dat,
  input  logic             i_pol,
  input  logic [WIDTH-1:0] i_thresh,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_sat,
  output logic             o_hit,
  output logic             o_hit_pulse,
  output logic [WIDTH-1:0] o_run_len,
  output logic             o_run_vld
);

  localparam logic [WIDTH-1:0] MAX = '1;

  state_t           state, state_nxt;
  logic             match;
  logic [WIDTH-1:0] cnt_nxt;
  logic             capture;
  logic             hit_pulse_nxt;

  assign match = (i_dat == i_pol);

  // Next count is only consumed on enabled edges; flopr_en holds otherwise.
  always_comb begin
    cnt_nxt   = '0;
    state_nxt = state;
    if (match) begin
      cnt_nxt = (o_cnt == MAX) ? MAX : o_cnt + 1'b1;
    end
    if (i_en) begin
      if (!match)
        state_nxt = ST_IDLE;
      else if (cnt_nxt == MAX)
        state_nxt = ST_SAT;
      else
        state_nxt = ST_RUN;
    end
  end

  assign capture       = i_en && !match && (o_cnt != '0);
  assign hit_pulse_nxt = i_en && (i_thresh != '0) &&
                         (cnt_nxt == i_thresh) && (o_cnt != i_thresh);

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state       <= ST_IDLE;
      o_run_vld   <= 1'b0;
      o_hit_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_run_vld   <= capture;
      o_hit_pulse <= hit_pulse_nxt;
    end
  end

  flopr_en #(.WIDTH(WIDTH)) u_cnt (
    .clk (clk),
    .clr (i_sclr),
    .en  (i_en),
    .d   (cnt_nxt),
    .q   (o_cnt)
  );

  flopr_en #(.WIDTH(WIDTH)) u_run_len (
    .clk (clk),
    .clr (i_sclr),
    .en  (capture),
    .d   (o_cnt),
    .q   (o_run_len)
  );

  assign o_sat = (state == ST_SAT);
  assign o_hit = (i_thresh != '0) && (o_cnt >= i_thresh);

endmodule

// File: tb/tb_run_len_detect.sv
module tb_run_len_detect;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             i_sclr, i_en, i_dat, i_pol;
  logic [WIDTH-1:0] i_thresh;
  logic [WIDTH-1:0] o_cnt, o_run_len;
  logic             o_sat, o_hit, o_hit_pulse, o_run_vld;

  int checks = 0;
  int errors = 0;
  int pulses;

  run_len_detect #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .i_sclr      (i_sclr),
    .i_en        (i_en),
    .i_dat       (i_dat),
    .i_pol       (i_pol),
    .i_thresh    (i_thresh),
    .o_cnt       (o_cnt),
    .o_sat       (o_sat),
    .o_hit       (o_hit),
    .o_hit_pulse (o_hit_pulse),
    .o_run_len   (o_run_len),
    .o_run_vld   (o_run_vld)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply inputs, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic sclr, input logic en, input logic dat);
    i_sclr = sclr;
    i_en   = en;
    i_dat  = dat;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int cnt, input bit sat, input bit hit,
                         input bit hp, input int len, input bit vld);
    check({tag, ".cnt"},  32'(o_cnt),       32'(cnt));
    check({tag, ".sat"},  32'(o_sat),       32'(sat));
    check({tag, ".hit"},  32'(o_hit),       32'(hit));
    check({tag, ".hp"},   32'(o_hit_pulse), 32'(hp));
    check({tag, ".len"},  32'(o_run_len),   32'(len));
    check({tag, ".vld"},  32'(o_run_vld),   32'(vld));
  endtask

  initial begin
    i_sclr = 1'b1; i_en = 1'b0; i_dat = 1'b0; i_pol = 1'b1; i_thresh = '0;
    #2;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      i_pol    = 1'($urandom);
      i_thresh = WIDTH'($urandom);
      step(1'b1, 1'($urandom), 1'($urandom));
    end
    chk_all("reset", 0, 0, 0, 0, 0, 0);

    // Basic run: thresh 3, data 1,1,1,1,0
    i_pol = 1'b1; i_thresh = 4'd3;
    step(1'b0, 1'b1, 1'b1); chk_all("basic1", 1, 0, 0, 0, 0, 0);
    step(1'b0, 1'b1, 1'b1); chk_all("basic2", 2, 0, 0, 0, 0, 0);
    step(1'b0, 1'b1, 1'b1); chk_all("basic3", 3, 0, 1, 1, 0, 0);
    step(1'b0, 1'b1, 1'b1); chk_all("basic4", 4, 0, 1, 0, 0, 0);
    step(1'b0, 1'b1, 1'b0); chk_all("basic5", 0, 0, 0, 0, 4, 1);
    step(1'b0, 1'b1, 1'b0); chk_all("basic6", 0, 0, 0, 0, 4, 0);

    // Saturation: 20 ones with thresh 15, then a zero
    i_thresh = 4'd15;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b1, 1'b1);
      if (o_hit_pulse) pulses++;
      chk_all($sformatf("sat%0d", i), (i < 15) ? i : 15, i >= 15, i >= 15, i == 15, 4, 0);
    end
    check("sat.pulse_count", 32'(pulses), 32'd1);
    step(1'b0, 1'b1, 1'b0); chk_all("sat_end", 0, 0, 0, 0, 15, 1);

    // Enable gating: 1,1, three disabled zeros, then enabled 1
    i_thresh = 4'd3;
    step(1'b0, 1'b1, 1'b1); chk_all("gate1", 1, 0, 0, 0, 15, 0);
    step(1'b0, 1'b1, 1'b1); chk_all("gate2", 2, 0, 0, 0, 15, 0);
    step(1'b0, 1'b0, 1'b0); chk_all("gate3", 2, 0, 0, 0, 15, 0);
    step(1'b0, 1'b0, 1'b0); chk_all("gate4", 2, 0, 0, 0, 15, 0);
    step(1'b0, 1'b0, 1'b0); chk_all("gate5", 2, 0, 0, 0, 15, 0);
    step(1'b0, 1'b1, 1'b1); chk_all("gate6", 3, 0, 1, 1, 15, 0);

    // Zero polarity, threshold disabled: clear, then 0,0,1
    step(1'b1, 1'b1, 1'b0); chk_all("clr0", 0, 0, 0, 0, 0, 0);
    i_pol = 1'b0; i_thresh = '0;
    step(1'b0, 1'b1, 1'b0); chk_all("zpol1", 1, 0, 0, 0, 0, 0);
    step(1'b0, 1'b1, 1'b0); chk_all("zpol2", 2, 0, 0, 0, 0, 0);
    step(1'b0, 1'b1, 1'b1); chk_all("zpol3", 0, 0, 0, 0, 2, 1);

    // Clear mid-run: five ones, then clear with a zero on the data line
    i_pol = 1'b1;
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 1'b1);
    chk_all("mid5", 5, 0, 0, 0, 2, 0);
    step(1'b1, 1'b1, 1'b0); chk_all("midclr", 0, 0, 0, 0, 0, 0);

    // Length-1 runs separated by single mismatches
    step(1'b0, 1'b1, 1'b1); chk_all("short1", 1, 0, 0, 0, 0, 0);
    step(1'b0, 1'b1, 1'b0); chk_all("short2", 0, 0, 0, 0, 1, 1);
    step(1'b0, 1'b1, 1'b0); chk_all("short3", 0, 0, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
